// File: rtl/neural_decompressor_if.sv
// AXI-Stream style handshake bundle used on both sides of neural_decompressor.
// USER_WIDTH is 2 on the compressed input side (packet type) and 1 on the sample side (spike flag).
interface neural_decompressor_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/neural_decompressor.sv
// Decoder for the compressed neural stream (RAW/DELTA/RUN/SPIKE) into one sample per cycle.
// Define NEURAL_DECOMP_SATURATE_EN for signed saturating DELTA addition; default wraps.
module neural_decompressor #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RUN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  neural_decompressor_if.slave  s_axis,
  neural_decompressor_if.master m_axis,
  input  logic                 cfg_enable,
  input  logic                 err_clear,
  output logic                 err_no_ref,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [15:0]          spike_count
);

  localparam logic [1:0] PKT_RAW   = 2'b00;
  localparam logic [1:0] PKT_DELTA = 2'b01;
  localparam logic [1:0] PKT_RUN   = 2'b10;
  localparam logic [1:0] PKT_SPIKE = 2'b11;

  localparam logic [0:0] ST_DECODE   = 1'b0;
  localparam logic [0:0] ST_EMIT_RUN = 1'b1;

  localparam logic [RUN_WIDTH-1:0] RUN_ONE = RUN_WIDTH'(1);

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] ref_q;
  logic                  has_ref;
  logic [RUN_WIDTH-1:0]  run_remaining;
  logic                  run_last;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_user;
  logic                  out_last;

  logic                  slot_free;
  logic                  accept;
  logic                  out_fire;
  logic [RUN_WIDTH-1:0]  run_len;
  logic [DATA_WIDTH-1:0] delta_sum;

  logic                  emit;
  logic [DATA_WIDTH-1:0] emit_data;
  logic                  emit_user;
  logic                  emit_last;
  logic                  ref_load;
  logic [DATA_WIDTH-1:0] ref_next;
  logic                  run_start;
  logic                  err_set;
  logic                  spike_inc;

  assign slot_free = !out_valid || m_axis.tready;
  assign s_axis.tready = cfg_enable && (state == ST_DECODE) && slot_free;
  assign accept    = s_axis.tvalid && s_axis.tready;
  assign out_fire  = out_valid && m_axis.tready;
  assign run_len   = s_axis.tdata[RUN_WIDTH-1:0];

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;

`ifdef NEURAL_DECOMP_SATURATE_EN
  logic [DATA_WIDTH:0] wide_sum;

  // One extra sign bit exposes overflow as a mismatch between the top two bits.
  always_comb begin
    wide_sum  = {ref_q[DATA_WIDTH-1], ref_q} + {s_axis.tdata[DATA_WIDTH-1], s_axis.tdata};
    delta_sum = wide_sum[DATA_WIDTH-1:0];
    if (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]) begin
      delta_sum = wide_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  assign delta_sum = ref_q + s_axis.tdata;
`endif

  always_comb begin
    emit      = 1'b0;
    emit_data = '0;
    emit_user = 1'b0;
    emit_last = 1'b0;
    ref_load  = 1'b0;
    ref_next  = ref_q;
    run_start = 1'b0;
    err_set   = 1'b0;
    spike_inc = 1'b0;

    if (state == ST_EMIT_RUN) begin
      if (slot_free) begin
        emit      = 1'b1;
        emit_data = ref_q;
        emit_last = (run_remaining == RUN_ONE) ? run_last : 1'b0;
      end
    end else if (accept) begin
      case (s_axis.tuser)
        PKT_RAW, PKT_SPIKE: begin
          emit      = 1'b1;
          emit_data = s_axis.tdata;
          emit_user = (s_axis.tuser == PKT_SPIKE);
          emit_last = s_axis.tlast;
          ref_load  = 1'b1;
          ref_next  = s_axis.tdata;
          spike_inc = (s_axis.tuser == PKT_SPIKE);
        end
        PKT_DELTA: begin
          if (has_ref) begin
            emit      = 1'b1;
            emit_data = delta_sum;
            emit_last = s_axis.tlast;
            ref_load  = 1'b1;
            ref_next  = delta_sum;
          end else begin
            err_set = 1'b1;
          end
        end
        default: begin
          if (!has_ref || (run_len == '0)) begin
            err_set = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_data = ref_q;
            run_start = (run_len > RUN_ONE);
            // Multi-sample runs defer tlast to the final repeat.
            emit_last = (run_len > RUN_ONE) ? 1'b0 : s_axis.tlast;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= emit_data;
      out_user  <= emit_user;
      out_last  <= emit_last;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q   <= '0;
      has_ref <= 1'b0;
    end else if (ref_load) begin
      ref_q   <= ref_next;
      has_ref <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_DECODE;
      run_remaining <= '0;
      run_last      <= 1'b0;
    end else if (run_start) begin
      state         <= ST_EMIT_RUN;
      run_remaining <= run_len - RUN_ONE;
      run_last      <= s_axis.tlast;
    end else if ((state == ST_EMIT_RUN) && slot_free) begin
      run_remaining <= run_remaining - RUN_ONE;
      if (run_remaining == RUN_ONE) begin
        state <= ST_DECODE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_no_ref   <= 1'b0;
      sample_count <= '0;
      spike_count  <= '0;
    end else begin
      if (err_set) begin
        err_no_ref <= 1'b1;
      end else if (err_clear) begin
        err_no_ref <= 1'b0;
      end
      if (out_fire) begin
        sample_count <= sample_count + CNT_WIDTH'(1);
      end
      if (spike_inc) begin
        spike_count <= spike_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_neural_decompressor.sv
// Directed and randomized checks of neural_decompressor against a packet-level reference model.
// Build with NEURAL_DECOMP_SATURATE_EN to check the saturating DELTA variant.
module tb_neural_decompressor;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_enable = 1'b0;
  logic          err_clear = 1'b0;
  logic          err_no_ref;
  logic [CW-1:0] sample_count;
  logic [15:0]   spike_count;

  neural_decompressor_if #(.DATA_WIDTH(DW), .USER_WIDTH(2)) s_if ();
  neural_decompressor_if #(.DATA_WIDTH(DW), .USER_WIDTH(1)) m_if ();

  neural_decompressor #(.DATA_WIDTH(DW), .RUN_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .cfg_enable   (cfg_enable),
    .err_clear    (err_clear),
    .err_no_ref   (err_no_ref),
    .sample_count (sample_count),
    .spike_count  (spike_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  // Samples are packed as {data, spike, last}.
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] obs_q[$];
  logic [DW-1:0] m_ref;
  bit            m_has;
  bit            m_err;
  int unsigned   m_spk;
  int unsigned   obs_total;
  bit            rand_bp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
`ifdef NEURAL_DECOMP_SATURATE_EN
    longint hi;
    longint lo;
    s  = longint'($signed(a)) + longint'($signed(b));
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`else
    s = (longint'(a) + longint'(b)) % (longint'(1) << DW);
`endif
    return s[DW-1:0];
  endfunction

  task automatic model_feed(input logic [1:0] ty, input logic [DW-1:0] d, input logic l);
    int unsigned n;
    case (ty)
      2'b00, 2'b11: begin
        m_ref = d;
        m_has = 1'b1;
        exp_q.push_back({d, (ty == 2'b11), l});
        if (ty == 2'b11) m_spk++;
      end
      2'b01: begin
        if (m_has) begin
          m_ref = model_add(m_ref, d);
          exp_q.push_back({m_ref, 1'b0, l});
        end else begin
          m_err = 1'b1;
        end
      end
      default: begin
        n = int'(d) % (1 << RW);
        if (!m_has || n == 0) begin
          m_err = 1'b1;
        end else begin
          for (int unsigned i = 1; i <= n; i++) exp_q.push_back({m_ref, 1'b0, (i == n) ? l : 1'b0});
        end
      end
    endcase
  endtask

  // Output monitor: records handshakes and checks that stalled outputs hold.
  logic          stall_prev = 1'b0;
  logic [DW+1:0] held;
  always @(negedge clk) begin
    if (stall_prev) begin
      chk("hold_valid", 64'(m_if.tvalid), 64'd1);
      chk("hold_data", 64'({m_if.tdata, m_if.tuser, m_if.tlast}), 64'(held));
    end
    stall_prev = rst_n && m_if.tvalid && !m_if.tready;
    held = {m_if.tdata, m_if.tuser, m_if.tlast};
    if (rst_n && m_if.tvalid && m_if.tready) begin
      obs_q.push_back({m_if.tdata, m_if.tuser, m_if.tlast});
      obs_total++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) m_if.tready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [1:0] ty, input logic [DW-1:0] d, input logic l);
    int unsigned n = 0;
    s_if.tvalid = 1'b1;
    s_if.tuser  = ty;
    s_if.tdata  = d;
    s_if.tlast  = l;
    @(negedge clk);
    while (!s_if.tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!s_if.tready) begin
      chk("send_timeout", 64'd0, 64'd1);
      s_if.tvalid = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      model_feed(ty, d, l);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    s_if.tvalid = 1'b0;
    while ((obs_q.size() != exp_q.size() || m_if.tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) chk({tag, "_sample"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_sample_count"}, 64'(sample_count), 64'(obs_total));
    chk({tag, "_spike_count"}, 64'(spike_count), 64'(m_spk & 32'hFFFF));
    chk({tag, "_err"}, 64'(err_no_ref), 64'(m_err));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ref = '0;
    m_has = 1'b0;
    m_err = 1'b0;
    m_spk = 0;
    obs_total = 0;
    while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ovf_exp;
    logic [DW-1:0] neg_exp;
    int unsigned   cnt;
    int unsigned   saved;
    logic [1:0]    ty;
    logic [DW-1:0] d;

    m_if.tready = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_if.tdata), 64'd0);
    chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
    chk("rst_sample_count", 64'(sample_count), 64'd0);
    chk("rst_spike_count", 64'(spike_count), 64'd0);
    chk("rst_err", 64'(err_no_ref), 64'd0);
    rst_n = 1'b1;
    m_ref = '0; m_has = 1'b0; m_err = 1'b0; m_spk = 0; obs_total = 0;
    cfg_enable = 1'b1;

    // RAW then DELTAs, each visible one cycle after accept
    send(2'b00, 16'h0100, 1'b0);
    chk("t1_lat0", 64'({m_if.tvalid, m_if.tdata}), 64'({1'b1, 16'h0100}));
    send(2'b01, 16'h0005, 1'b0);
    chk("t1_lat1", 64'({m_if.tvalid, m_if.tdata}), 64'({1'b1, 16'h0105}));
    send(2'b01, 16'hFFFE, 1'b1);
    chk("t1_lat2", 64'({m_if.tvalid, m_if.tdata}), 64'({1'b1, 16'h0103}));
    drain("t1");
    chk("t1_sc3", 64'(sample_count), 64'd3);

    // RUN of 4 with tlast
    send(2'b00, 16'h0042, 1'b0);
    send(2'b10, 16'h0004, 1'b1);
    s_if.tvalid = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (!s_if.tready && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("t2_ready_low", 64'(cnt), 64'd3);
    drain("t2");

    // missing reference and zero-length run
    do_reset();
    send(2'b01, 16'h0003, 1'b0);
    chk("t3_delta_err", 64'(err_no_ref), 64'(m_err));
    chk("t3_no_out", 64'(m_if.tvalid), 64'd0);
    s_if.tvalid = 1'b0;
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    m_err = 1'b0;
    chk("t3_cleared", 64'(err_no_ref), 64'd0);
    send(2'b00, 16'h0007, 1'b0);
    err_clear = 1'b1;
    send(2'b10, 16'h0000, 1'b1);
    err_clear = 1'b0;
    chk("t3_set_wins", 64'(err_no_ref), 64'd1);
    drain("t3");

    // backpressure mid-run
    do_reset();
    send(2'b00, 16'h1234, 1'b0);
    send(2'b10, 16'h0003, 1'b1);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4_stall", 64'({m_if.tvalid, m_if.tdata}), 64'({1'b1, 16'h1234}));
    end
    m_if.tready = 1'b1;
    drain("t4");
    chk("t4_sc4", 64'(sample_count), 64'd4);

    // DELTA overflow at both ends of the signed range
`ifdef NEURAL_DECOMP_SATURATE_EN
    ovf_exp = 16'h7FFF;
    neg_exp = 16'h8000;
`else
    ovf_exp = 16'h8000;
    neg_exp = 16'h7FFF;
`endif
    send(2'b00, 16'h7FFF, 1'b0);
    send(2'b01, 16'h0001, 1'b0);
    chk("t5_pos_ovf", 64'(m_if.tdata), 64'(ovf_exp));
    send(2'b00, 16'h8000, 1'b0);
    send(2'b01, 16'hFFFF, 1'b0);
    chk("t5_neg_ovf", 64'(m_if.tdata), 64'(neg_exp));
    drain("t5");

    // SPIKE, then reset in the middle of a run
    do_reset();
    send(2'b11, 16'h0900, 1'b1);
    chk("t6_spike_flag", 64'(m_if.tuser), 64'd1);
    drain("t6");
    chk("t6_spike1", 64'(spike_count), 64'd1);
    send(2'b00, 16'h0010, 1'b0);
    send(2'b10, 16'h0008, 1'b1);
    s_if.tvalid = 1'b0;
    cnt = 0;
    while (obs_q.size() < 4 && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("t6_reached_repeats", 64'(obs_q.size() >= 4), 64'd1);
    do_reset();
    chk("t6_rst_out", 64'({m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}), 64'd0);
    chk("t6_rst_counts", 64'({sample_count, spike_count, err_no_ref}), 64'd0);
    saved = obs_q.size();
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_repeats", 64'(obs_q.size()), 64'(saved));
    send(2'b01, 16'h0005, 1'b0);
    chk("t6_delta_err", 64'(err_no_ref), 64'd1);
    drain("t6b");

    // enable drop mid-run: the run finishes but no new word is taken
    send(2'b00, 16'h0055, 1'b0);
    send(2'b10, 16'h0003, 1'b0);
    cfg_enable = 1'b0;
    s_if.tdata = 16'h0099;
    s_if.tuser = 2'b00;
    repeat (8) @(posedge clk);
    #1;
    chk("t7_run_done", 64'(obs_q.size()), 64'd4);
    chk("t7_ready_off", 64'(s_if.tready), 64'd0);
    cfg_enable = 1'b1;
    send(2'b00, 16'h0099, 1'b1);
    drain("t7");

    // randomized traffic with backpressure and enable gaps
    do_reset();
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        s_if.tvalid = 1'b0;
        cfg_enable = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        cfg_enable = 1'b1;
      end
      ty = 2'($urandom_range(0, 3));
      d  = (ty == 2'b10) ? 16'($urandom_range(0, 5)) : 16'($urandom);
      send(ty, d, 1'($urandom_range(0, 1)));
    end
    s_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    rand_bp = 1'b0;
    m_if.tready = 1'b1;
    drain("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/neural_decompressor.md
Name: neural_decompressor

Overview:
- Receive-side decoder for the compressed neural stream produced by the compressor pipeline.
- Consumes AXI-Stream words tagged with a 2-bit packet type (RAW/DELTA/RUN/SPIKE) and reconstructs the uncompressed sample stream, one sample per cycle.
- Sits on the host/readback path; used for loopback verification and for downstream analysis.
- Outputs reconstructed samples with a per-sample spike flag, plus status counters.

Parameters:
- DATA_WIDTH, 16: sample and packet word width.
- RUN_WIDTH, 16: low bits of tdata used as the run length for RUN packets; must be <= DATA_WIDTH.
- CNT_WIDTH, 32: width of sample_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  compressed word
- s_axis_tuser  in  2  packet type: 00 RAW, 01 DELTA, 10 RUN, 11 SPIKE
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  packet boundary
- m_axis_tdata  out  DATA_WIDTH  reconstructed sample
- m_axis_tuser  out  1  spike flag for this sample
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last sample of the packet
- cfg_enable  in  1  decoder enable
- err_clear  in  1  clears err_no_ref
- err_no_ref  out  1  sticky flag: DELTA/RUN received with no reference
- sample_count  out  CNT_WIDTH  output handshakes, wraps
- spike_count  out  16  SPIKE packets decoded, wraps

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge):
  - All outputs 0; state=DECODE; ref=0; has_ref=0; run_remaining=0.
  - Reset mid-run abandons the run; no further repeats are emitted.
- Output stage is a single register. slot_free = !m_axis_tvalid || m_axis_tready.
- m_axis_tdata, m_axis_tuser and m_axis_tlast are held stable while m_axis_tvalid && !m_axis_tready.
- s_axis_tready = cfg_enable && state==DECODE && slot_free.
- Accept = s_axis_tvalid && s_axis_tready. Latency: output valid on the cycle after accept.
- State DECODE, on accept:
  - RAW: ref<=tdata, has_ref<=1; emit tdata with spike=0.
  - SPIKE: same as RAW but spike=1; spike_count++.
  - DELTA: if has_ref, ref<=ref+tdata (tdata is two's complement), emit new ref with spike=0. Otherwise drop the word, set err_no_ref, emit nothing.
  - RUN: N = tdata[RUN_WIDTH-1:0]. If !has_ref or N==0, drop the word and set err_no_ref (N==0 also sets it). Otherwise emit ref with spike=0. If N>1, run_remaining<=N-1 and go to EMIT_RUN.
  - tlast: m_axis_tlast follows s_axis_tlast for single-sample packets. A dropped word's tlast is discarded.
- State EMIT_RUN:
  - Each cycle with slot_free, emit ref again with spike=0 and decrement run_remaining.
  - When run_remaining reaches 0, return to DECODE. s_axis_tready stays low throughout.
  - A RUN packet's tlast is latched and asserted only on the final repeat.
- cfg_enable low: no new input is accepted; an in-progress run completes; the output register still drains.
- Counters:
  - sample_count increments on m_axis_tvalid && m_axis_tready.
  - spike_count increments at SPIKE accept.
  - Both wrap modulo their width.
- err_no_ref:
  - Sticky until err_clear=1, which clears it.
  - If err_clear coincides with a new error, the set wins.
- Delta arithmetic: default is modulo 2^DATA_WIDTH (wraps).

Optional Feature:
- Macro NEURAL_DECOMP_SATURATE_EN.
- Defined: DELTA addition is signed and saturating, clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: addition wraps modulo 2^DATA_WIDTH.
- All other behaviour is identical.

Test Plan:
- RAW 0x0100, DELTA 0x0005, DELTA 0xFFFE, m_axis_tready=1 -> outputs 0x0100, 0x0105, 0x0103 on consecutive cycles, each one cycle after accept; sample_count=3.
- RAW 0x0042, then RUN 0x0004 with tlast=1 -> five outputs of 0x0042; m_axis_tlast only on the 5th; s_axis_tready low for 3 cycles during EMIT_RUN.
- DELTA 0x0003 with no prior RAW -> no output, err_no_ref=1; err_clear pulse -> err_no_ref=0; RUN 0x0000 after a RAW -> err_no_ref=1, no extra output.
- RAW 0x1234, RUN 0x0003, m_axis_tready held low 5 cycles mid-run -> m_axis_tdata stable at 0x1234; four total samples delivered with no loss or duplication; sample_count=4.
- RAW 0x7FFF, DELTA 0x0001 -> output 0x8000 without the macro, 0x7FFF with NEURAL_DECOMP_SATURATE_EN.
- SPIKE 0x0900 -> m_axis_tuser=1, spike_count=1. Then RAW 0x0010, RUN 0x0008, rst_n low for 1 cycle after 2 repeats -> all outputs 0, no further repeats; a subsequent DELTA sets err_no_ref.
